// File: rtl/occ_req_scheduler.sv
// Occurrence-table read scheduler: turns k/l line-address pairs into one or two
// in-order memory reads, pairs the responses and delivers them with their tag.
module occ_req_scheduler #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 42,
    parameter int unsigned TAG_W  = 9,
    parameter int unsigned DATA_W = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr_k,
    input  logic [ADDR_W-1:0] req_addr_l,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              stall,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              out_valid,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data_k,
    output logic [DATA_W-1:0] out_data_l,
    input  logic              out_ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OST_W = PTR_W + 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_K = 2'd1,
        ISSUE_L = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]   issue_ptr_q, issue_ptr_d;
    logic [PTR_W-1:0]   rsp_ptr_q, rsp_ptr_d;
    logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0]   occ_q, occ_d;
    logic [CNT_W-1:0]   unissued_q, unissued_d;
    logic [OST_W-1:0]   outstanding_q, outstanding_d;
    logic [DEPTH-1:0]   got_k_q, got_k_d;
    logic [DEPTH-1:0]   got_l_q, got_l_d;
    logic [DEPTH-1:0]   dup_q, dup_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]  mem_req_addr_q, mem_req_addr_d;
    logic               out_valid_q, out_valid_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic [DATA_W-1:0]  out_data_k_q, out_data_k_d;
    logic [DATA_W-1:0]  out_data_l_q, out_data_l_d;

    logic [ADDR_W-1:0]  addr_k_q [DEPTH];
    logic [ADDR_W-1:0]  addr_k_d [DEPTH];
    logic [ADDR_W-1:0]  addr_l_q [DEPTH];
    logic [ADDR_W-1:0]  addr_l_d [DEPTH];
    logic [TAG_W-1:0]   tag_q    [DEPTH];
    logic [TAG_W-1:0]   tag_d    [DEPTH];
    logic [DATA_W-1:0]  data_k_q [DEPTH];
    logic [DATA_W-1:0]  data_k_d [DEPTH];
    logic [DATA_W-1:0]  data_l_q [DEPTH];
    logic [DATA_W-1:0]  data_l_d [DEPTH];

    logic accept;
    logic transfer;
    logic cur_dup;
    logic advance;
    logic mem_hs;
    logic rsp_ok;

    // A delivery in the same cycle frees a slot, so a full buffer can still accept.
    assign transfer = out_valid_q && out_ready;
    assign stall    = (occ_q == CNT_W'(DEPTH)) && !transfer;
    assign accept   = req_valid && !stall;
    assign cur_dup  = dup_q[issue_ptr_q];
    assign mem_hs   = mem_req_valid_q && mem_req_ready;
    assign advance  = mem_hs && ((state_q == ISSUE_L) || ((state_q == ISSUE_K) && cur_dup));
    assign rsp_ok   = mem_rsp_valid && (outstanding_q != '0);

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign out_valid     = out_valid_q;
    assign out_tag       = out_tag_q;
    assign out_data_k    = out_data_k_q;
    assign out_data_l    = out_data_l_q;

    always_comb begin
        state_d         = state_q;
        alloc_ptr_d     = alloc_ptr_q;
        issue_ptr_d     = issue_ptr_q;
        rsp_ptr_d       = rsp_ptr_q;
        head_ptr_d      = head_ptr_q;
        occ_d           = occ_q;
        unissued_d      = unissued_q;
        outstanding_d   = outstanding_q;
        got_k_d         = got_k_q;
        got_l_d         = got_l_q;
        dup_d           = dup_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_addr_d  = mem_req_addr_q;
        out_valid_d     = out_valid_q;
        out_tag_d       = out_tag_q;
        out_data_k_d    = out_data_k_q;
        out_data_l_d    = out_data_l_q;
        addr_k_d        = addr_k_q;
        addr_l_d        = addr_l_q;
        tag_d           = tag_q;
        data_k_d        = data_k_q;
        data_l_d        = data_l_q;

        // Allocation
        if (accept) begin
            addr_k_d[alloc_ptr_q] = req_addr_k;
            addr_l_d[alloc_ptr_q] = req_addr_l;
            tag_d[alloc_ptr_q]    = req_tag;
            dup_d[alloc_ptr_q]    = (req_addr_k == req_addr_l);
            alloc_ptr_d           = alloc_ptr_q + PTR_W'(1);
        end
        occ_d       = occ_q + CNT_W'(accept) - CNT_W'(transfer);
        issue_ptr_d = issue_ptr_q + PTR_W'(advance);
        unissued_d  = unissued_q + CNT_W'(accept) - CNT_W'(advance);

        // Issue FSM; a pair accepted this cycle is forwarded straight to the port
        if ((state_q == ISSUE_K) && mem_req_ready && !cur_dup) begin
            state_d        = ISSUE_L;
            mem_req_addr_d = addr_l_q[issue_ptr_q];
        end else if ((state_q == IDLE) || advance) begin
            if (unissued_d != '0) begin
                state_d        = ISSUE_K;
                mem_req_addr_d = (accept && (issue_ptr_d == alloc_ptr_q)) ?
                                 req_addr_k : addr_k_q[issue_ptr_d];
            end else begin
                state_d = IDLE;
            end
        end
        mem_req_valid_d = (state_d != IDLE);

        // Response pairing: k half first, duplicates complete on the k response
        outstanding_d = outstanding_q + OST_W'(mem_hs) - OST_W'(rsp_ok);
        if (rsp_ok) begin
            if (!got_k_q[rsp_ptr_q]) begin
                data_k_d[rsp_ptr_q] = mem_rsp_data;
                got_k_d[rsp_ptr_q]  = 1'b1;
                if (dup_q[rsp_ptr_q]) begin
                    data_l_d[rsp_ptr_q] = mem_rsp_data;
                    got_l_d[rsp_ptr_q]  = 1'b1;
                    rsp_ptr_d           = rsp_ptr_q + PTR_W'(1);
                end
            end else begin
                data_l_d[rsp_ptr_q] = mem_rsp_data;
                got_l_d[rsp_ptr_q]  = 1'b1;
                rsp_ptr_d           = rsp_ptr_q + PTR_W'(1);
            end
        end

        // Delivery
        head_ptr_d = head_ptr_q + PTR_W'(transfer);
        if (transfer) begin
            got_k_d[head_ptr_q] = 1'b0;
            got_l_d[head_ptr_q] = 1'b0;
        end
        if (!out_valid_q || transfer) begin
            if (got_k_q[head_ptr_d] && got_l_q[head_ptr_d]) begin
                out_valid_d  = 1'b1;
                out_tag_d    = tag_q[head_ptr_d];
                out_data_k_d = data_k_q[head_ptr_d];
                out_data_l_d = data_l_q[head_ptr_d];
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            alloc_ptr_q     <= '0;
            issue_ptr_q     <= '0;
            rsp_ptr_q       <= '0;
            head_ptr_q      <= '0;
            occ_q           <= '0;
            unissued_q      <= '0;
            outstanding_q   <= '0;
            got_k_q         <= '0;
            got_l_q         <= '0;
            dup_q           <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            out_valid_q     <= 1'b0;
            out_tag_q       <= '0;
            out_data_k_q    <= '0;
            out_data_l_q    <= '0;
        end else begin
            state_q         <= state_d;
            alloc_ptr_q     <= alloc_ptr_d;
            issue_ptr_q     <= issue_ptr_d;
            rsp_ptr_q       <= rsp_ptr_d;
            head_ptr_q      <= head_ptr_d;
            occ_q           <= occ_d;
            unissued_q      <= unissued_d;
            outstanding_q   <= outstanding_d;
            got_k_q         <= got_k_d;
            got_l_q         <= got_l_d;
            dup_q           <= dup_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_addr_q  <= mem_req_addr_d;
            out_valid_q     <= out_valid_d;
            out_tag_q       <= out_tag_d;
            out_data_k_q    <= out_data_k_d;
            out_data_l_q    <= out_data_l_d;
        end
    end

    // Payload storage is qualified by the got/dup flags, so it needs no reset
    always_ff @(posedge clk) begin
        addr_k_q <= addr_k_d;
        addr_l_q <= addr_l_d;
        tag_q    <= tag_d;
        data_k_q <= data_k_d;
        data_l_q <= data_l_d;
    end

    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rst)
        !(mem_rsp_valid && (outstanding_q == '0)))
        else $error("occ_req_scheduler: memory response with no outstanding read");

endmodule
